// File: rtl/banked_mem_responder_if.sv
// Cache-side request/response bundle for the four-bank memory responder.
// master = cache controller, slave = memory responder.
interface banked_mem_responder_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] data_out;
    logic              stall;
    logic [3:0]        busy;
    logic              err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, stall, busy, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, stall, busy, err
    );
endinterface

// File: rtl/banked_mem_responder.sv
// Four-bank interleaved memory responder: per-bank occupancy counters, fixed 2-cycle read pipe.
// Optional request checking is enabled by defining BANKMEM_ERR_CHECK_EN.
module banked_mem_responder #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned BANK_AW  = 13,
    parameter int unsigned BANK_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    banked_mem_responder_if.slave  bus
);
    localparam int unsigned NBANK  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 1 << BANK_AW;
    localparam int unsigned CNT_W  = $clog2(BANK_LAT);

    logic [DATA_W-1:0] mem [NBANK][DEPTH];
    logic [CNT_W-1:0]  cnt [NBANK];

    logic [1:0]         bank;
    logic [BANK_AW-1:0] row;
    logic [NBANK-1:0]   busy_v;
    logic               illegal;
    logic               rd_acc;
    logic               wr_acc;
    logic               stall_c;
    logic               err_c;

    logic               s1_valid, s2_valid;
    logic [DATA_W-1:0]  s1_data, s2_data;

    assign bank = bus.addr[2:1];
    assign row  = BANK_AW'(bus.addr[ADDR_W-1:3]);

    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            busy_v[b] = (cnt[b] != '0);
        end
    end

    // Request qualification: accept, stall and error decode for this cycle.
    always_comb begin
        illegal = 1'b0;
        err_c   = 1'b0;
        rd_acc  = 1'b0;
        wr_acc  = 1'b0;
        stall_c = 1'b0;
`ifdef BANKMEM_ERR_CHECK_EN
        illegal = (bus.rd & bus.wr) | ((bus.rd | bus.wr) & bus.addr[0]);
        err_c   = illegal;
        wr_acc  = bus.wr & ~illegal & ~busy_v[bank];
        rd_acc  = bus.rd & ~illegal & ~busy_v[bank];
`else
        // rd&wr collapses to a write; the read half is dropped.
        wr_acc  = bus.wr & ~busy_v[bank];
        rd_acc  = bus.rd & ~bus.wr & ~busy_v[bank];
`endif
        stall_c = (bus.rd | bus.wr) & busy_v[bank] & ~illegal;
    end

`ifndef BANKMEM_ERR_CHECK_EN
    // Byte offset bit is truncated when checking is off.
    logic addr_lsb_unused;
    assign addr_lsb_unused = bus.addr[0];
`endif

    // Per-bank occupancy counters, loaded on accept and drained to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if ((rd_acc | wr_acc) && (bank == 2'(b))) begin
                    cnt[b] <= CNT_W'(BANK_LAT - 1);
                end else if (cnt[b] != '0) begin
                    cnt[b] <= cnt[b] - CNT_W'(1);
                end
            end
        end
    end

    // Array and read-data pipe; data is qualified by the valid bits below.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[bank][row] <= bus.data_in;
        end
        if (rd_acc) begin
            s1_data <= mem[bank][row];
        end
        s2_data <= s1_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= rd_acc;
            s2_valid <= s1_valid;
        end
    end

    assign bus.data_out = s2_valid ? s2_data : '0;
    assign bus.busy     = busy_v;
    assign bus.stall    = stall_c;
    assign bus.err      = err_c;
endmodule
